// File: rtl/fifo_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_frame_pkg
// Purpose  : Shared types and helpers for the FIFO frame reader.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_frame_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        PAY  = 2'd1,
        CSUM = 2'd2
    } frame_state_t;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : frame_out_reg
// Purpose  : Single-entry valid/ready output register carrying data and last.
// Revision : 1.0 - initial release
// ============================================================================
module frame_out_reg
    import fifo_frame_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    output logic                  load_ok
);

    assign load_ok = !m_valid || m_ready;

    // Callers only raise load when load_ok is set, so a held word is never overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_data  <= load_data;
            m_valid <= 1'b1;
            m_last  <= load_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_frame_reader
// Purpose  : Pops length-prefixed frames from a FWFT FIFO into a valid/ready
//            stream with m_last. Optional trailing XOR checksum: FRAME_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_frame_reader
    import fifo_frame_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int MAX_LEN     = 64,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   rclk,
    input  logic                   reset,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_rdata,
    output logic                   fifo_rd_en,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   frame_done,
    output logic [COUNT_WIDTH-1:0] frame_count,
`ifdef FRAME_CHECKSUM_EN
    output logic                   csum_err,
`endif
    output logic                   len_err
);

    localparam int LEN_W = len_w(MAX_LEN);
    // Header compare width covers both the data word and MAX_LEN.
    localparam int HW    = (DATA_WIDTH > LEN_W) ? DATA_WIDTH : LEN_W;

    frame_state_t     state;
    frame_state_t     state_nxt;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] remaining_nxt;
    logic [HW-1:0]    hdr_len;
    logic             hdr_bad;
    logic             load_ok;
    logic             load;
    logic             load_last;
    logic             len_err_nxt;
    logic             handoff;

    assign hdr_len = HW'(fifo_rdata);
    assign hdr_bad = (hdr_len == '0) || (hdr_len > HW'(MAX_LEN));
    assign handoff = m_valid && m_ready && m_last;

`ifdef FRAME_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_acc;
    logic [DATA_WIDTH-1:0] csum_acc_nxt;
    logic                  csum_err_nxt;
`endif

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        fifo_rd_en    = 1'b0;
        load          = 1'b0;
        load_last     = 1'b0;
        len_err_nxt   = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        csum_acc_nxt  = csum_acc;
        csum_err_nxt  = 1'b0;
`endif
        case (state)
            HDR: begin
                // Header pops never touch the output register, so a waiting last word does not block them.
                fifo_rd_en = !fifo_empty;
                if (!fifo_empty) begin
                    if (hdr_bad) begin
                        len_err_nxt = 1'b1;
                    end else begin
                        remaining_nxt = hdr_len[LEN_W-1:0];
                        state_nxt     = PAY;
`ifdef FRAME_CHECKSUM_EN
                        csum_acc_nxt  = '0;
`endif
                    end
                end
            end
            PAY: begin
                fifo_rd_en = !fifo_empty && load_ok;
                if (!fifo_empty && load_ok) begin
                    load          = 1'b1;
                    load_last     = (remaining == LEN_W'(1));
                    remaining_nxt = remaining - LEN_W'(1);
`ifdef FRAME_CHECKSUM_EN
                    csum_acc_nxt  = csum_acc ^ fifo_rdata;
                    if (remaining == LEN_W'(1)) state_nxt = CSUM;
`else
                    if (remaining == LEN_W'(1)) state_nxt = HDR;
`endif
                end
            end
`ifdef FRAME_CHECKSUM_EN
            CSUM: begin
                fifo_rd_en = !fifo_empty;
                if (!fifo_empty) begin
                    csum_err_nxt = (fifo_rdata != csum_acc);
                    state_nxt    = HDR;
                end
            end
`endif
            default: state_nxt = HDR;
        endcase
    end

    always_ff @(posedge rclk or negedge reset) begin
        if (!reset) begin
            state       <= HDR;
            remaining   <= '0;
            len_err     <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            state      <= state_nxt;
            remaining  <= remaining_nxt;
            len_err    <= len_err_nxt;
            frame_done <= handoff;
            if (handoff) frame_count <= frame_count + COUNT_WIDTH'(1);
        end
    end

`ifdef FRAME_CHECKSUM_EN
    always_ff @(posedge rclk or negedge reset) begin
        if (!reset) begin
            csum_acc <= '0;
            csum_err <= 1'b0;
        end else begin
            csum_acc <= csum_acc_nxt;
            csum_err <= csum_err_nxt;
        end
    end
`endif

    frame_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out (
        .clk       (rclk),
        .rst_n     (reset),
        .load      (load),
        .load_data (fifo_rdata),
        .load_last (load_last),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .load_ok   (load_ok)
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_frame_reader
// Purpose  : Directed self-checking bench for fifo_frame_reader (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_frame_reader;

    localparam int DW = 8;
    localparam int ML = 64;
    // Narrow counter so the wrap boundary is reachable in a few hundred frames.
    localparam int CW = 8;

    logic          rclk       = 1'b0;
    logic          reset      = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic          m_ready    = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          frame_done;
    logic [CW-1:0] frame_count;
    logic          len_err;

    logic [DW-1:0] q[$];
    int vectors     = 0;
    int miscompares = 0;

    always #5 rclk = ~rclk;

    fifo_frame_reader #(
        .DATA_WIDTH  (DW),
        .MAX_LEN     (ML),
        .COUNT_WIDTH (CW)
    ) dut (
        .rclk        (rclk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_rdata  (fifo_rdata),
        .fifo_rd_en  (fifo_rd_en),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .len_err     (len_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty = (q.size() == 0);
        fifo_rdata = (q.size() != 0) ? q[0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] w);
        q.push_back(w);
        refresh();
    endtask

    // Decide the pop from settled inputs, cross one edge, then retire the head.
    task automatic step();
        logic p;
        #1;
        p = fifo_rd_en && !fifo_empty;
        @(posedge rclk);
        #1;
        if (p) void'(q.pop_front());
        refresh();
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d, input logic l);
        chk({tag, "_valid"}, 32'(m_valid), 32'(v));
        chk({tag, "_data"},  32'(m_data),  32'(d));
        chk({tag, "_last"},  32'(m_last),  32'(l));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        m_ready = 1'b1;
        #12;
        chk_out("rst", 1'b0, 8'h00, 1'b0);
        chk("rst_done",  32'(frame_done),  32'd0);
        chk("rst_lenerr", 32'(len_err),    32'd0);
        chk("rst_count", 32'(frame_count), 32'd0);
        @(posedge rclk); #2;
        reset = 1'b1;

        // Frame of three words, ready held high
        push(8'd3); push(8'hA1); push(8'hB2); push(8'hC3);
        step();
        chk("t1_hdr_valid", 32'(m_valid), 32'd0);
        chk("t1_hdr_rden",  32'(fifo_rd_en), 32'd1);
        step(); chk_out("t1_w0", 1'b1, 8'hA1, 1'b0);
        step(); chk_out("t1_w1", 1'b1, 8'hB2, 1'b0);
        step(); chk_out("t1_w2", 1'b1, 8'hC3, 1'b1);
        chk("t1_done_early", 32'(frame_done), 32'd0);
        step();
        chk("t1_done",  32'(frame_done),  32'd1);
        chk("t1_count", 32'(frame_count), 32'd1);
        chk("t1_idle",  32'(m_valid),     32'd0);
        step();
        chk("t1_done_pulse", 32'(frame_done), 32'd0);

        // Same frame with backpressure after the first word
        push(8'd3); push(8'hA1); push(8'hB2); push(8'hC3);
        step();
        step(); chk_out("t2_w0", 1'b1, 8'hA1, 1'b0);
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("t2_stall", 1'b1, 8'hA1, 1'b0);
            chk("t2_stall_rden", 32'(fifo_rd_en), 32'd0);
        end
        m_ready = 1'b1;
        step(); chk_out("t2_w1", 1'b1, 8'hB2, 1'b0);
        step(); chk_out("t2_w2", 1'b1, 8'hC3, 1'b1);
        step();
        chk("t2_done",  32'(frame_done),  32'd1);
        chk("t2_count", 32'(frame_count), 32'd2);

        // Illegal headers 0 and MAX_LEN+1, then a one-word frame
        reset = 1'b0; #1; reset = 1'b1;
        chk("t3_rst_count", 32'(frame_count), 32'd0);
        push(8'd0); push(8'd65); push(8'd1); push(8'h5A);
        step(); chk("t3_err0",  32'(len_err), 32'd1);
        chk("t3_err0_valid", 32'(m_valid), 32'd0);
        step(); chk("t3_err65", 32'(len_err), 32'd1);
        step(); chk("t3_err_clr", 32'(len_err), 32'd0);
        chk("t3_hdr_valid", 32'(m_valid), 32'd0);
        step(); chk_out("t3_w0", 1'b1, 8'h5A, 1'b1);
        step();
        chk("t3_done",  32'(frame_done),  32'd1);
        chk("t3_count", 32'(frame_count), 32'd1);

        // Reset mid-frame after 2 of 5 payload words
        push(8'd5); push(8'h01); push(8'h02);
        step();
        step(); chk_out("t4_w0", 1'b1, 8'h01, 1'b0);
        step(); chk_out("t4_w1", 1'b1, 8'h02, 1'b0);
        step(); chk("t4_stall_valid", 32'(m_valid), 32'd0);
        reset = 1'b0; #1;
        chk_out("t4_rst", 1'b0, 8'h00, 1'b0);
        chk("t4_rst_count", 32'(frame_count), 32'd0);
        reset = 1'b1;
        push(8'd2); push(8'h11); push(8'h22);
        step(); chk("t4_hdr_valid", 32'(m_valid), 32'd0);
        step(); chk_out("t4_n0", 1'b1, 8'h11, 1'b0);
        step(); chk_out("t4_n1", 1'b1, 8'h22, 1'b1);
        step();
        chk("t4_done",  32'(frame_done),  32'd1);
        chk("t4_count", 32'(frame_count), 32'd1);

        // Counter wrap: back-to-back one-word frames up to all-ones, then one more
        reset = 1'b0; #1; reset = 1'b1;
        for (int i = 0; i < 255; i++) begin
            push(8'd1);
            push(8'(i));
        end
        for (int n = 0; n < 2000 && frame_count != 8'hFF; n++) step();
        chk("t5_count_max", 32'(frame_count), 32'hFF);
        chk("t5_drained", 32'(q.size()), 32'd0);
        step();
        push(8'd1); push(8'hEE);
        step();
        step(); chk_out("t5_w0", 1'b1, 8'hEE, 1'b1);
        step();
        chk("t5_done", 32'(frame_done),  32'd1);
        chk("t5_wrap", 32'(frame_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_frame_reader.md
Name: fifo_frame_reader

Overview:
- Read-side consumer for the switch's async_fifo, clocked in the read domain.
- Pops a length-prefixed byte stream from the FIFO's first-word-fall-through read port and turns it into a valid/ready stream with frame delimiting (m_last).
- Keeps a frame counter and flags malformed frames.
- Sits between the ingress CDC FIFO and the switch forwarding logic.

Parameters:
- DATA_WIDTH, 8: FIFO and output data width. The header byte and payload bytes are each DATA_WIDTH bits.
- MAX_LEN, 64: largest legal payload length in words. A header value greater than MAX_LEN is a length error.
- COUNT_WIDTH, 16: width of frame_count.

Ports:
- rclk  in  1  read-domain clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- fifo_empty  in  1  FIFO empty flag. fifo_rdata is valid whenever this is 0.
- fifo_rdata  in  DATA_WIDTH  FIFO head word (first-word fall-through).
- fifo_rd_en  out  1  pop request. The head is consumed on an rclk edge where fifo_rd_en=1 and fifo_empty=0.
- m_data  out  DATA_WIDTH  payload word.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream ready.
- m_last  out  1  marks the final payload word of a frame; qualified by m_valid.
- frame_done  out  1  one-cycle pulse when the last word of a frame is handed off.
- frame_count  out  COUNT_WIDTH  number of completed frames; wraps modulo 2^COUNT_WIDTH.
- len_err  out  1  one-cycle pulse on an illegal header.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=HDR; m_valid=0, m_last=0, m_data=0.
  - frame_done=0, len_err=0, frame_count=0.
  - The remaining-length counter is cleared.
- Reset mid-frame: the partial frame is abandoned and the FIFO is not flushed. After release, the next popped word is treated as a header.
- Output stage is one register:
  - It may load when m_valid=0 or m_ready=1.
  - m_valid/m_data/m_last hold stable while m_valid=1 and m_ready=0.
- fifo_rd_en is combinational:
  - HDR: fifo_rd_en = !fifo_empty.
  - PAY: fifo_rd_en = !fifo_empty && (!m_valid || m_ready).
- Latency: a payload word popped at edge k appears on m_data with m_valid=1 after edge k. Sustained throughput is 1 word/cycle with m_ready held high.
- State HDR: on a pop, len = fifo_rdata.
  - len==0 or len>MAX_LEN: pulse len_err for the next cycle, stay in HDR, output nothing.
  - Otherwise: remaining = len, go to PAY. The header is never output.
- State PAY: each pop loads the output register with m_last = (remaining==1) and decrements remaining.
  - When the popped word is the last one, go to HDR (or CSUM with the feature enabled).
  - A header can be popped in the same cycle the last payload word waits in the output register.
- Handoff: on m_valid && m_ready && m_last, frame_done pulses for the following cycle and frame_count increments, wrapping from 2^COUNT_WIDTH-1 to 0.
- fifo_empty in mid-frame: stall with no pop. m_valid drops after the current word is accepted. There is no timeout.
- Simultaneous events:
  - Accept and reload in the same cycle is allowed with no bubble.
  - len_err and frame_done may pulse in the same cycle.

Optional Feature:
- FRAME_CHECKSUM_EN defined:
  - Each frame carries one trailing checksum word equal to the XOR of all payload words.
  - After the last payload pop, the FSM enters CSUM and pops one word without outputting it.
  - On mismatch, output csum_err (extra port, 1 bit) pulses for one cycle after the pop. frame_count still increments.
  - Then return to HDR.
- Undefined: no CSUM state, no csum_err port, no trailing word expected.

Decomposition:
- Package fifo_frame_pkg:
  - typedef frame_state_t {HDR, PAY, CSUM}.
  - LEN_W = $clog2(MAX_LEN+1) helper.
  - Default DATA_WIDTH constant shared with async_fifo benches.
- One natural sub-module: frame_out_reg. It is a single-entry valid/ready output register holding data and last, and exposes load_ok = !m_valid || m_ready.

Test Plan:
- Push header 3 then 0xA1,0xB2,0xC3 with m_ready=1 -> m_data A1,B2,C3 on 3 consecutive cycles, m_last only with C3, frame_done=1 once, frame_count=1.
- Same frame with m_ready=0 for 4 cycles after the first word -> m_data holds A1 stable, fifo_rd_en=0 during the stall, all 3 words delivered in order afterwards.
- Header 0, then header 65 (MAX_LEN=64), then header 1, 0x5A -> two len_err pulses, one frame containing 0x5A with m_last=1, frame_count=1.
- Assert reset after 2 of 5 payload words, release, push header 2, 0x11,0x22 -> outputs zero during reset; then 0x11,0x22 are output, m_last on 0x22, frame_count=1.
- Set frame_count to 16'hFFFF by pushing 65535 one-word frames, then push one more -> frame_count wraps to 0.
- FRAME_CHECKSUM_EN: push header 2, 0x0F, 0xF0, checksum 0xFF -> no csum_err. Same frame with checksum 0x00 -> csum_err pulses once and frame_count still increments.
